// File: rtl/prog_loader_ram.sv
// prog_loader_ram
//   Byte-strobed single-port-write / single-port-read program RAM with an
//   integrated serial boot loader. The loader listens to a UART byte stream.
//   It waits for a magic byte string, then a 32-bit big-endian word count N.
//   It then takes N 32-bit words (MSB byte first) and packs them into RAM
//   lines starting at BASE_LINE. A partial final line is zero-padded. The
//   core is held in reset (sys_rst_no low) for the whole load plus
//   RST_CYCLES cycles.
//
// Optional feature macro: PROG_CHECKSUM_EN
//   Defined: a trailing checksum byte follows the data. The 8-bit sum of all
//   data bytes plus the checksum must be zero.
//   Undefined: no checksum byte and no sum accumulator.
//
// Ports
//   clk_i        clock (single domain)
//   rst_ni       asynchronous active-low reset
//   wr_addr_i    CPU write line address
//   wr_data_i    CPU write data
//   wr_strb_i    CPU byte enables (any set bit is a write)
//   rd_en_i      CPU read enable
//   rd_addr_i    CPU read line address
//   rd_data_o    registered read data (1-cycle latency, old data on collision)
//   rx_byte_i    received UART byte
//   rx_valid_i   one-cycle strobe qualifying rx_byte_i
//   prog_mode_o  high while receiving the length or data
//   sys_rst_no   active-low reset to the core
//   load_done_o  one-cycle pulse when sys_rst_no is released after a good load
//   load_err_o   sticky error flag (oversize, timeout, bad checksum)
module prog_loader_ram #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned RAM_DEPTH      = 8192,
  parameter logic [63:0] MAGIC          = 64'h54434F5245544553,
  parameter int unsigned MAGIC_LEN      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned BASE_LINE      = 0,
  parameter string       INIT_FILE      = ""
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [$clog2(RAM_DEPTH)-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]       wr_strb_i,
  input  logic                          rd_en_i,
  input  logic [$clog2(RAM_DEPTH)-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  input  logic [7:0]                    rx_byte_i,
  input  logic                          rx_valid_i,
  output logic                          prog_mode_o,
  output logic                          sys_rst_no,
  output logic                          load_done_o,
  output logic                          load_err_o
);

  localparam int unsigned AW  = $clog2(RAM_DEPTH);
  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned WPL = DATA_WIDTH / 32;
  localparam int unsigned WIW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW  = $clog2(RST_CYCLES + 1);

  localparam logic [7:0] Magic0 = MAGIC[8*(MAGIC_LEN-1) +: 8];

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StMagic, StLength, StData, StCheck, StRelease
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StMagic, StLength, StData, StRelease
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Image preload only; not part of the reset behaviour.
  initial begin
    for (int i = 0; i < int'(RAM_DEPTH); i++) mem[i] = '0;
  end

  logic                  ld_we;
  logic [AW-1:0]         ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  // Loader write wins; a simultaneous CPU write is dropped.
  always_ff @(posedge clk_i) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else begin
      for (int b = 0; b < int'(NB); b++) begin
        if (wr_strb_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  state_e                state;
  logic [2:0]            mag_idx;
  logic [1:0]            byte_cnt;
  logic [23:0]           len_sr;
  logic [23:0]           word_sr;
  logic [31:0]           words_left;
  logic [WIW-1:0]        word_idx;
  logic [DATA_WIDTH-1:0] line_buf;
  logic [AW-1:0]         line_addr;
  logic [TW-1:0]         idle_cnt;
  logic [RW-1:0]         rst_cnt;
  logic                  sys_rst_n;
  logic                  load_done;
  logic                  load_err;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]            sum;
  logic [7:0]            sum_next;
`endif

  logic [31:0]           cur_word;
  logic [31:0]           full_len;
  logic [32:0]           lines_need;
  logic                  too_big;
  logic [7:0]            magic_exp;
  logic                  timed_state;
  logic                  timeout_hit;
  logic                  last_word;
  logic                  line_full;
  logic [DATA_WIDTH-1:0] line_ins;

  always_comb begin
    cur_word    = {word_sr, rx_byte_i};
    full_len    = {len_sr, rx_byte_i};
    lines_need  = (33'(full_len) + 33'(WPL - 1)) / 33'(WPL);
    too_big     = lines_need > 33'(RAM_DEPTH - BASE_LINE);
    magic_exp   = 8'(MAGIC >> (8 * (MAGIC_LEN - 1 - 32'(mag_idx))));
    timed_state = (state != StIdle) && (state != StRelease);
    timeout_hit = timed_state && !rx_valid_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    last_word   = (words_left == 32'd1);
    line_full   = (word_idx == WIW'(WPL - 1));
    // Lanes not yet filled in line_buf are zero, so OR-ing places the word
    // and leaves the zero padding for a partial final line.
    line_ins    = line_buf | (DATA_WIDTH'(cur_word) << (32 * word_idx));
`ifdef PROG_CHECKSUM_EN
    sum_next    = sum + rx_byte_i;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= StIdle;
      mag_idx    <= '0;
      byte_cnt   <= '0;
      len_sr     <= '0;
      word_sr    <= '0;
      words_left <= '0;
      word_idx   <= '0;
      line_buf   <= '0;
      line_addr  <= '0;
      idle_cnt   <= '0;
      rst_cnt    <= '0;
      ld_we      <= 1'b0;
      ld_addr    <= '0;
      ld_data    <= '0;
      sys_rst_n  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      ld_we     <= 1'b0;
      load_done <= 1'b0;

      if (!timed_state || rx_valid_i) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + 1'b1;

      if (timeout_hit) begin
        // sys_rst_no deliberately untouched: a partial image may be in RAM.
        state    <= StIdle;
        load_err <= 1'b1;
      end else begin
        unique case (state)
          StIdle: begin
            if (rx_valid_i && (rx_byte_i == Magic0)) begin
              load_err <= 1'b0;
              mag_idx  <= 3'd1;
              byte_cnt <= '0;
              state    <= (MAGIC_LEN == 1) ? StLength : StMagic;
            end
          end

          StMagic: begin
            if (rx_valid_i) begin
              if (rx_byte_i == magic_exp) begin
                if (mag_idx == 3'(MAGIC_LEN - 1)) begin
                  state    <= StLength;
                  byte_cnt <= '0;
                end else begin
                  mag_idx <= mag_idx + 3'd1;
                end
              end else begin
                // Mismatching byte is consumed, not re-tested against byte 0.
                state <= StIdle;
              end
            end
          end

          StLength: begin
            if (rx_valid_i) begin
              if (byte_cnt != 2'd3) begin
                len_sr   <= {len_sr[15:0], rx_byte_i};
                byte_cnt <= byte_cnt + 2'd1;
              end else begin
                byte_cnt   <= '0;
                words_left <= full_len;
                word_idx   <= '0;
                line_buf   <= '0;
                line_addr  <= AW'(BASE_LINE);
`ifdef PROG_CHECKSUM_EN
                sum        <= '0;
`endif
                if (too_big) begin
                  load_err <= 1'b1;
                  state    <= StIdle;
                end else if (full_len == 32'd0) begin
`ifdef PROG_CHECKSUM_EN
                  state     <= StCheck;
`else
                  state     <= StRelease;
                  rst_cnt   <= '0;
                  sys_rst_n <= 1'b0;
`endif
                end else begin
                  state     <= StData;
                  sys_rst_n <= 1'b0;
                end
              end
            end
          end

          StData: begin
            if (rx_valid_i) begin
`ifdef PROG_CHECKSUM_EN
              sum <= sum_next;
`endif
              if (byte_cnt != 2'd3) begin
                word_sr  <= {word_sr[15:0], rx_byte_i};
                byte_cnt <= byte_cnt + 2'd1;
              end else begin
                byte_cnt   <= '0;
                words_left <= words_left - 32'd1;
                if (last_word || line_full) begin
                  ld_we     <= 1'b1;
                  ld_addr   <= line_addr;
                  ld_data   <= line_ins;
                  line_addr <= line_addr + 1'b1;
                  line_buf  <= '0;
                  word_idx  <= '0;
                end else begin
                  line_buf <= line_ins;
                  word_idx <= word_idx + 1'b1;
                end
                if (last_word) begin
`ifdef PROG_CHECKSUM_EN
                  state <= StCheck;
`else
                  state   <= StRelease;
                  rst_cnt <= '0;
`endif
                end
              end
            end
          end

`ifdef PROG_CHECKSUM_EN
          StCheck: begin
            if (rx_valid_i) begin
              if (sum_next == 8'd0) begin
                state     <= StRelease;
                rst_cnt   <= '0;
                sys_rst_n <= 1'b0;
              end else begin
                // Core stays in reset: the image in RAM is not trustworthy.
                load_err <= 1'b1;
                state    <= StIdle;
              end
            end
          end
`endif

          StRelease: begin
            if (rst_cnt == RW'(RST_CYCLES - 1)) begin
              sys_rst_n <= 1'b1;
              load_done <= 1'b1;
              state     <= StIdle;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end

          default: state <= StIdle;
        endcase
      end
    end
  end

  assign prog_mode_o = (state == StLength) || (state == StData);
  assign sys_rst_no  = sys_rst_n;
  assign load_done_o = load_done;
  assign load_err_o  = load_err;

endmodule

// File: tb/tb_prog_loader_ram.sv
// Directed bench for prog_loader_ram: CPU port, full and partial loads, magic
// corruption, oversize length, timeout, mid-load reset and (when the checksum
// macro is defined) checksum pass/fail.
module tb_prog_loader_ram;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int TO    = 40;
  localparam int RC    = 4;
  localparam int BL    = 2;
`ifdef PROG_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clk;
  logic          rst_n;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   wr_strb;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          prog_mode;
  logic          sys_rst_n;
  logic          load_done;
  logic          load_err;

  int n_cmp = 0;
  int n_bad = 0;
  int low_cycles = 0;
  int done_cnt = 0;
  logic [31:0]   wq[$];
  logic [DW-1:0] got;

  prog_loader_ram #(
    .DATA_WIDTH    (DW),
    .RAM_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES(TO),
    .RST_CYCLES    (RC),
    .BASE_LINE     (BL)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_strb_i  (wr_strb),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .prog_mode_o(prog_mode),
    .sys_rst_no (sys_rst_n),
    .load_done_o(load_done),
    .load_err_o (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!sys_rst_n) low_cycles++;
    if (load_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_magic();
    logic [63:0] m;
    m = 64'h54434F5245544553;
    for (int i = 0; i < 8; i++) send_byte(m[63-8*i -: 8]);
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8]);
  endtask

  // Sends the words in wq, then the checksum byte when enabled (bad adds 1).
  task automatic send_words(input int bad);
    logic [7:0] s;
    s = 8'd0;
    foreach (wq[k]) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(wq[k][31-8*i -: 8]);
        s = s + wq[k][31-8*i -: 8];
      end
    end
    if (CK != 0) send_byte(8'(8'd0 - s + 8'(bad)));
  endtask

  task automatic load(input int bad);
    send_magic();
    send_len(32'(wq.size()));
    send_words(bad);
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [DW-1:0] d, input logic [15:0] s);
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
    @(posedge clk);
    #1;
    wr_strb = '0;
  endtask

  task automatic read_line(input logic [3:0] a, output logic [DW-1:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    d     = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    n_cmp++; if (rd_data !== '0) begin n_bad++;
      $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_cmp++; if (prog_mode !== 1'b0) begin n_bad++;
      $display("FAIL reset_prog_mode got=%b exp=0", prog_mode); end
    n_cmp++; if (sys_rst_n !== 1'b1) begin n_bad++;
      $display("FAIL reset_sys_rst_n got=%b exp=1", sys_rst_n); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++;
      $display("FAIL reset_load_done got=%b exp=0", load_done); end
    n_cmp++; if (load_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_load_err got=%b exp=0", load_err); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_cpu_rw();
    cpu_write(4'd10, {DW{1'b1}}, 16'hFFFF);
    cpu_write(4'd10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'h00F0);
    read_line(4'd10, got);
    n_cmp++; if (got !== 128'hFFFFFFFF_FFFFFFFF_8899AABB_FFFFFFFF) begin n_bad++;
      $display("FAIL cpu_strobe got=%h exp=ffffffffffffffff8899aabbffffffff", got); end
    // Read and write the same line in one cycle: old data comes back.
    wr_addr = 4'd10; wr_data = '0; wr_strb = 16'hFFFF; rd_en = 1'b1; rd_addr = 4'd10;
    @(posedge clk);
    #1;
    wr_strb = '0; rd_en = 1'b0;
    n_cmp++; if (rd_data !== 128'hFFFFFFFF_FFFFFFFF_8899AABB_FFFFFFFF) begin n_bad++;
      $display("FAIL cpu_rdw_old got=%h exp=ffffffffffffffff8899aabbffffffff", rd_data); end
    read_line(4'd10, got);
    n_cmp++; if (got !== '0) begin n_bad++;
      $display("FAIL cpu_after_write got=%h exp=0", got); end
    read_line(4'd11, got);
    n_cmp++; if (got !== '0) begin n_bad++;
      $display("FAIL cpu_zero_init got=%h exp=0", got); end
  endtask

  task automatic test_load4();
    wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    low_cycles = 0; done_cnt = 0;
    send_magic();
    n_cmp++; if (prog_mode !== 1'b1) begin n_bad++;
      $display("FAIL load4_prog_mode_len got=%b exp=1", prog_mode); end
    n_cmp++; if (sys_rst_n !== 1'b1) begin n_bad++;
      $display("FAIL load4_rst_before_len got=%b exp=1", sys_rst_n); end
    send_len(32'd4);
    n_cmp++; if (sys_rst_n !== 1'b0) begin n_bad++;
      $display("FAIL load4_rst_in_data got=%b exp=0", sys_rst_n); end
    send_words(0);
    tick(RC + 2);
    n_cmp++; if (done_cnt !== 1) begin n_bad++;
      $display("FAIL load4_done_pulses got=%0d exp=1", done_cnt); end
    n_cmp++; if (low_cycles !== 16 + CK + RC) begin n_bad++;
      $display("FAIL load4_low_cycles got=%0d exp=%0d", low_cycles, 16 + CK + RC); end
    n_cmp++; if (sys_rst_n !== 1'b1 || load_err !== 1'b0 || prog_mode !== 1'b0) begin
      n_bad++; $display("FAIL load4_end_flags got rst=%b err=%b pm=%b exp 1 0 0",
                        sys_rst_n, load_err, prog_mode); end
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h44444444_33333333_22222222_11111111) begin n_bad++;
      $display("FAIL load4_line got=%h exp=44444444333333332222222211111111", got); end
  endtask

  task automatic test_partial();
    cpu_write(4'(BL + 1), {DW{1'b1}}, 16'hFFFF);
    wq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    low_cycles = 0; done_cnt = 0;
    load(0);
    tick(RC + 2);
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h44444444_33333333_22222222_11111111) begin n_bad++;
      $display("FAIL partial_line0 got=%h exp=44444444333333332222222211111111", got); end
    read_line(4'(BL + 1), got);
    n_cmp++; if (got !== {96'h0, 32'h55555555}) begin n_bad++;
      $display("FAIL partial_pad got=%h exp=00000000000000000000000055555555", got); end
    n_cmp++; if (low_cycles !== 20 + CK + RC || done_cnt !== 1) begin n_bad++;
      $display("FAIL partial_rst_done got low=%0d done=%0d exp low=%0d done=1",
               low_cycles, done_cnt, 20 + CK + RC); end
  endtask

  task automatic test_magic_corrupt();
    logic [7:0] seq [13];
    seq = '{8'h54, 8'h43, 8'h4F, 8'h52, 8'h58, 8'h00, 8'h00, 8'h00, 8'h01,
            8'hAA, 8'hAA, 8'hAA, 8'hAA};
    foreach (seq[i]) send_byte(seq[i]);
    tick(2);
    n_cmp++; if (prog_mode !== 1'b0 || sys_rst_n !== 1'b1 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL magic_bad_flags got pm=%b rst=%b err=%b exp 0 1 0",
                        prog_mode, sys_rst_n, load_err); end
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h44444444_33333333_22222222_11111111) begin n_bad++;
      $display("FAIL magic_bad_ram got=%h exp=44444444333333332222222211111111", got); end
    // "TCT" + "CORETES": the mismatching 'T' must not restart the match.
    seq = '{8'h54, 8'h43, 8'h54, 8'h43, 8'h4F, 8'h52, 8'h45, 8'h54, 8'h45, 8'h53,
            8'h00, 8'h00, 8'h00};
    foreach (seq[i]) send_byte(seq[i]);
    n_cmp++; if (prog_mode !== 1'b0) begin n_bad++;
      $display("FAIL magic_no_reeval got pm=%b exp=0", prog_mode); end
  endtask

  task automatic test_oversize_and_reset();
    send_magic();
    send_len(32'(DEPTH * 4 + 1));
    n_cmp++; if (load_err !== 1'b1 || prog_mode !== 1'b0 || sys_rst_n !== 1'b1) begin
      n_bad++; $display("FAIL oversize_flags got err=%b pm=%b rst=%b exp 1 0 1",
                        load_err, prog_mode, sys_rst_n); end
    for (int i = 0; i < 4; i++) send_byte(8'hAA);
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h44444444_33333333_22222222_11111111) begin n_bad++;
      $display("FAIL oversize_ram got=%h exp=44444444333333332222222211111111", got); end
    send_magic();
    n_cmp++; if (load_err !== 1'b0) begin n_bad++;
      $display("FAIL magic_clears_err got=%b exp=0", load_err); end
    send_len(32'd57);  // one word beyond the 14 lines above BASE_LINE
    n_cmp++; if (load_err !== 1'b1) begin n_bad++;
      $display("FAIL oversize_57 got err=%b exp=1", load_err); end
    send_magic();
    send_len(32'd56);  // exactly fills the space
    n_cmp++; if (load_err !== 1'b0 || prog_mode !== 1'b1 || sys_rst_n !== 1'b0) begin
      n_bad++; $display("FAIL fit_56 got err=%b pm=%b rst=%b exp 0 1 0",
                        load_err, prog_mode, sys_rst_n); end
    send_byte(8'hDE);
    send_byte(8'hAD);
    read_line(4'(BL), got);  // makes rd_data non-zero before the reset
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rd_data !== '0 || prog_mode !== 1'b0 || sys_rst_n !== 1'b1 ||
                 load_done !== 1'b0 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_data got rd=%h pm=%b rst=%b done=%b err=%b exp 0 0 1 0 0",
                        rd_data, prog_mode, sys_rst_n, load_done, load_err); end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    n_cmp++; if (prog_mode !== 1'b0) begin n_bad++;
      $display("FAIL rst_to_idle got pm=%b exp=0", prog_mode); end
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h44444444_33333333_22222222_11111111) begin n_bad++;
      $display("FAIL rst_ram_kept got=%h exp=44444444333333332222222211111111", got); end
  endtask

  task automatic test_timeout();
    send_magic();
    send_len(32'd4);
    send_byte(8'h12);
    send_byte(8'h34);
    tick(TO - 5);
    n_cmp++; if (load_err !== 1'b0 || prog_mode !== 1'b1) begin n_bad++;
      $display("FAIL timeout_early got err=%b pm=%b exp 0 1", load_err, prog_mode); end
    tick(10);
    n_cmp++; if (load_err !== 1'b1 || sys_rst_n !== 1'b0 || prog_mode !== 1'b0) begin
      n_bad++; $display("FAIL timeout_hit got err=%b rst=%b pm=%b exp 1 0 0",
                        load_err, sys_rst_n, prog_mode); end
    wq = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F};
    done_cnt = 0;
    load(0);
    tick(RC + 2);
    n_cmp++; if (sys_rst_n !== 1'b1 || load_err !== 1'b0 || done_cnt !== 1) begin
      n_bad++; $display("FAIL timeout_recover got rst=%b err=%b done=%0d exp 1 0 1",
                        sys_rst_n, load_err, done_cnt); end
    read_line(4'(BL), got);
    n_cmp++; if (got !== 128'h0F0F0F0F_89ABCDEF_01234567_DEADBEEF) begin n_bad++;
      $display("FAIL timeout_recover_line got=%h exp=0f0f0f0f89abcdef01234567deadbeef", got);
    end
  endtask

  task automatic test_checksum();
    wq = '{32'hCAFEF00D, 32'h00000001, 32'h80808080, 32'h7F7F7F7F};
    done_cnt = 0;
    load(1);
    tick(RC + 2);
    n_cmp++; if (load_err !== 1'b1 || sys_rst_n !== 1'b0 || done_cnt !== 0) begin
      n_bad++; $display("FAIL cksum_bad got err=%b rst=%b done=%0d exp 1 0 0",
                        load_err, sys_rst_n, done_cnt); end
    load(0);
    tick(RC + 2);
    n_cmp++; if (load_err !== 1'b0 || sys_rst_n !== 1'b1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL cksum_good got err=%b rst=%b done=%0d exp 0 1 1",
                        load_err, sys_rst_n, done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0; rx_byte = '0; rx_valid = 1'b0;
    test_reset();
    test_cpu_rw();
    test_load4();
    test_partial();
    test_magic_corrupt();
    test_oversize_and_reset();
    test_timeout();
    if (CK != 0) test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
